mul_int8_arbiter: RTL

//  Round-robin scheduler sharing one multiplier_nbit instance (WIDTH-bit, low-half product) among NREQ requesters.

---
 rtl/mul_int8_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mul_int8_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit multiplier among NREQ requesters.
// Optional perf counters (perf_ops, perf_stall) are built when MUL_ARB_PERF_EN is defined.
module multiplier_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  assign p = a * b;
endmodule

module mul_int8_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_p,
  output logic [IDW-1:0]    res_id,
  output logic              busy,
  output logic [CNTW-1:0]   perf_ops,
  output logic [CNTW-1:0]   perf_stall
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] op_a, op_b, prod;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] res_p_q;
  logic [IDW-1:0]   res_id_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             accept;
  logic             res_hs;

  // First valid requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    res_valid = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = gnt;
        accept    = found;
        if (found) state_nx = CALC;
      end
      CALC: state_nx = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign res_hs = res_valid & res_ready;
  assign busy   = (state != IDLE);
  assign res_p  = res_p_q;
  assign res_id = res_id_q;

  multiplier_nbit #(.WIDTH(WIDTH)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      res_p_q  <= '0;
      res_id_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a  <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
        op_b  <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        op_id <= gnt_id;
        rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
      if (state == CALC) begin
        res_p_q  <= prod;
        res_id_q <= op_id;
      end
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic [CNTW-1:0] ops_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (res_hs && ops_q != '1) ops_q <= ops_q + 1'b1;
      if (res_valid && !res_ready && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule
